core_mau_arb: RTL and testbench

- Arbitrates the core's single memory access unit (MAU) port between instruction fetch (IF) and execute-stage load/store (EX).
- Sequences one outstanding memory transaction at a time.
- Generates mau_busy for the pipeline stall controller.
- Drains in-flight fetches discarded by an exception flush.

---
 rtl/core_mau_pkg.sv | 22 ++
 rtl/core_mau_arb.sv | 132 +++++++++++++
 tb/tb_core_mau_arb.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/core_mau_pkg.sv
// Shared types and default widths for the core MAU arbiter.
package core_mau_pkg;

  localparam int unsigned AW_DEF = 32;
  localparam int unsigned DW_DEF = 32;

  typedef enum logic [1:0] {
    StIdle,
    StBusyIf,
    StBusyEx,
    StDrainIf
  } mau_state_e;

  // Memory request payload at the default widths.
  typedef struct packed {
    logic                  we;
    logic [AW_DEF-1:0]     addr;
    logic [DW_DEF-1:0]     wdata;
    logic [DW_DEF/8-1:0]   be;
  } mem_req_t;

endpackage

// File: rtl/core_mau_arb.sv
// Arbitrates the single MAU port between instruction fetch and EX load/store,
// one outstanding transaction at a time, with IF starvation protection.
module core_mau_arb
  import core_mau_pkg::*;
#(
  parameter int unsigned AW         = AW_DEF,
  parameter int unsigned DW         = DW_DEF,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            if_req,
  input  logic [AW-1:0]   if_addr,
  output logic            if_ack,
  output logic [DW-1:0]   if_rdata,
  input  logic            ex_req,
  input  logic            ex_we,
  input  logic [AW-1:0]   ex_addr,
  input  logic [DW-1:0]   ex_wdata,
  input  logic [DW/8-1:0] ex_be,
  output logic            ex_ack,
  output logic [DW-1:0]   ex_rdata,
  output logic            mem_req,
  output logic            mem_we,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  output logic [DW/8-1:0] mem_be,
  input  logic            mem_ack,
  input  logic [DW-1:0]   mem_rdata,
  input  logic            flush,
  output logic            mau_busy
);

  localparam int unsigned BW = DW / 8;
  localparam int unsigned SW = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] StarveSat = SW'(STARVE_MAX);

  // Parametric view of the memory request payload.
  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [BW-1:0] be;
  } mem_cmd_t;

  mau_state_e    state_q, state_d;
  logic [SW-1:0] starve_q, starve_d;
  logic          mem_req_q, mem_req_d;
  mem_cmd_t      cmd_q, cmd_d;
  logic          if_live;
  logic          ex_win;

  always_comb begin
    state_d   = state_q;
    starve_d  = starve_q;
    mem_req_d = mem_req_q;
    cmd_d     = cmd_q;
    if_live   = if_req && !flush;
    ex_win    = 1'b0;
    unique case (state_q)
      StIdle: begin
        // EX wins unless IF has already waited through STARVE_MAX EX grants.
        ex_win = ex_req && !(if_live && (starve_q == StarveSat));
        if (ex_win) begin
          state_d   = StBusyEx;
          mem_req_d = 1'b1;
          cmd_d     = '{we: ex_we, addr: ex_addr, wdata: ex_wdata, be: ex_be};
          if (if_live && (starve_q != StarveSat)) begin
            starve_d = starve_q + SW'(1);
          end
        end else if (if_live) begin
          state_d   = StBusyIf;
          mem_req_d = 1'b1;
          cmd_d     = '{we: 1'b0, addr: if_addr, wdata: '0, be: '1};
          starve_d  = '0;
        end
      end
      StBusyEx: begin
        if (mem_ack) begin
          mem_req_d = 1'b0;
          state_d   = StIdle;
        end
      end
      StBusyIf: begin
        if (mem_ack) begin
          mem_req_d = 1'b0;
          state_d   = StIdle;
        end else if (flush) begin
          state_d = StDrainIf;
        end
      end
      StDrainIf: begin
        if (mem_ack) begin
          mem_req_d = 1'b0;
          state_d   = StIdle;
        end
      end
      default: begin
        state_d   = StIdle;
        mem_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      starve_q  <= '0;
      mem_req_q <= 1'b0;
      cmd_q     <= '0;
    end else begin
      state_q   <= state_d;
      starve_q  <= starve_d;
      mem_req_q <= mem_req_d;
      cmd_q     <= cmd_d;
    end
  end

  // A flush coinciding with the fetch ack kills the returned instruction.
  assign if_ack   = (state_q == StBusyIf) && mem_ack && !flush;
  assign ex_ack   = (state_q == StBusyEx) && mem_ack;
  assign if_rdata = mem_rdata;
  assign ex_rdata = mem_rdata;
  assign mau_busy = rst_n && ex_req && !ex_ack;

  assign mem_req   = mem_req_q;
  assign mem_we    = cmd_q.we;
  assign mem_addr  = cmd_q.addr;
  assign mem_wdata = cmd_q.wdata;
  assign mem_be    = cmd_q.be;

endmodule

// File: tb/tb_core_mau_arb.sv
// Directed bench for core_mau_arb; memory-side issues are checked against a scoreboard.
module tb_core_mau_arb;
  import core_mau_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_ack;
  logic [31:0] if_rdata;
  logic        ex_req;
  logic        ex_we;
  logic [31:0] ex_addr;
  logic [31:0] ex_wdata;
  logic [3:0]  ex_be;
  logic        ex_ack;
  logic [31:0] ex_rdata;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        flush;
  logic        mau_busy;

  core_mau_arb #(.AW(32), .DW(32), .STARVE_MAX(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .if_req   (if_req),
    .if_addr  (if_addr),
    .if_ack   (if_ack),
    .if_rdata (if_rdata),
    .ex_req   (ex_req),
    .ex_we    (ex_we),
    .ex_addr  (ex_addr),
    .ex_wdata (ex_wdata),
    .ex_be    (ex_be),
    .ex_ack   (ex_ack),
    .ex_rdata (ex_rdata),
    .mem_req  (mem_req),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_be   (mem_be),
    .mem_ack  (mem_ack),
    .mem_rdata(mem_rdata),
    .flush    (flush),
    .mau_busy (mau_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_issue(input logic we, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [3:0] be);
    exp_t e;
    e.we = we; e.addr = addr; e.wdata = wdata; e.be = be;
    sb.push_back(e);
  endtask

  task automatic chk_issue(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s: observed issue with empty scoreboard expected none", tag);
    end else begin
      e = sb.pop_front();
      chk({tag, "_req"}, mem_req, 1);
      chk({tag, "_we"}, mem_we, e.we);
      chk({tag, "_addr"}, mem_addr, e.addr);
      chk({tag, "_be"}, mem_be, e.be);
      if (e.we) chk({tag, "_wdata"}, mem_wdata, e.wdata);
    end
  endtask

  task automatic wait_busy(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      chk({tag, "_req_held"}, mem_req, 1);
      chk({tag, "_if_ack_lo"}, if_ack, 0);
      chk({tag, "_ex_ack_lo"}, ex_ack, 0);
      step();
    end
  endtask

  task automatic do_ack(input logic [31:0] rdata, input logic exp_if, input logic exp_ex,
                        input logic fl, input string tag);
    mem_rdata = rdata;
    mem_ack   = 1'b1;
    flush     = fl;
    #1;
    chk({tag, "_if_ack"}, if_ack, exp_if);
    chk({tag, "_ex_ack"}, ex_ack, exp_ex);
    if (exp_if) chk({tag, "_if_rdata"}, if_rdata, rdata);
    if (exp_ex) chk({tag, "_ex_rdata"}, ex_rdata, rdata);
    chk({tag, "_busy"}, mau_busy, ex_req & ~exp_ex);
    step();
    mem_ack   = 1'b0;
    mem_rdata = '0;
    flush     = 1'b0;
    chk({tag, "_req_drop"}, mem_req, 0);
    chk({tag, "_idle"}, dut.state_q, StIdle);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; if_req = 1'b0; if_addr = '0; ex_req = 1'b1; ex_we = 1'b0;
    ex_addr = '0; ex_wdata = '0; ex_be = '0; mem_ack = 1'b0; mem_rdata = '0; flush = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_mem_be", mem_be, 0);
    chk("rst_if_ack", if_ack, 0);
    chk("rst_ex_ack", ex_ack, 0);
    chk("rst_busy", mau_busy, 0);
    chk("rst_state", dut.state_q, StIdle);
    ex_req = 1'b0;
    rst_n  = 1'b1;
    step();

    // Single fetch.
    if_req = 1'b1; if_addr = 32'h100;
    expect_issue(1'b0, 32'h100, 32'h0, 4'hF);
    step();
    chk_issue("fetch");
    wait_busy(2, "fetch");
    do_ack(32'hCAFE0100, 1'b1, 1'b0, 1'b0, "fetch");
    if_req = 1'b0;
    step();
    chk("fetch_one_ack", if_ack, 0);
    chk("fetch_no_reissue", mem_req, 0);

    // Simultaneous IF and EX store: EX first.
    if_req = 1'b1; if_addr = 32'h104;
    ex_req = 1'b1; ex_we = 1'b1; ex_addr = 32'h2000; ex_wdata = 32'hDEADBEEF; ex_be = 4'h3;
    expect_issue(1'b1, 32'h2000, 32'hDEADBEEF, 4'h3);
    expect_issue(1'b0, 32'h104, 32'h0, 4'hF);
    #1;
    chk("store_busy_early", mau_busy, 1);
    step();
    chk_issue("store_first");
    chk("store_busy", mau_busy, 1);
    wait_busy(1, "store");
    do_ack(32'h0, 1'b0, 1'b1, 1'b0, "store");
    ex_req = 1'b0; ex_we = 1'b0;
    step();
    chk_issue("fetch_after_store");
    do_ack(32'h11110104, 1'b1, 1'b0, 1'b0, "fetch2");
    if_req = 1'b0;
    step();

    // Starvation: four EX grants, then IF forced through.
    if_req = 1'b1; if_addr = 32'h200;
    ex_req = 1'b1; ex_we = 1'b0; ex_wdata = '0; ex_be = 4'hF;
    for (int k = 0; k < 4; k++) begin
      ex_addr = 32'h3000 + 32'(4 * k);
      expect_issue(1'b0, ex_addr, 32'h0, 4'hF);
      step();
      chk_issue("starve_ex");
      do_ack(32'h5000 + 32'(k), 1'b0, 1'b1, 1'b0, "starve_ex");
    end
    chk("starve_sat", dut.starve_q, 4);
    ex_addr = 32'h3010;
    expect_issue(1'b0, 32'h200, 32'h0, 4'hF);
    expect_issue(1'b0, 32'h3010, 32'h0, 4'hF);
    step();
    chk_issue("starve_if");
    chk("starve_clr", dut.starve_q, 0);
    chk("starve_busy", mau_busy, 1);
    do_ack(32'h00000200, 1'b1, 1'b0, 1'b0, "starve_if");
    if_req = 1'b0;
    step();
    chk_issue("starve_ex_last");
    do_ack(32'h5004, 1'b0, 1'b1, 1'b0, "starve_ex_last");
    ex_req = 1'b0;
    step();

    // Flush before fetch ack: drain.
    if_req = 1'b1; if_addr = 32'h400;
    expect_issue(1'b0, 32'h400, 32'h0, 4'hF);
    step();
    chk_issue("drain");
    flush = 1'b1;
    step();
    chk("drain_state", dut.state_q, StDrainIf);
    flush = 1'b0; if_req = 1'b0;
    wait_busy(1, "drain");
    do_ack(32'hBAD0, 1'b0, 1'b0, 1'b0, "drain");

    // Flush coincident with fetch ack.
    if_req = 1'b1; if_addr = 32'h500;
    expect_issue(1'b0, 32'h500, 32'h0, 4'hF);
    step();
    chk_issue("flush_ack");
    do_ack(32'hBAD1, 1'b0, 1'b0, 1'b1, "flush_ack");
    if_req = 1'b0;
    step();
    chk("flush_ack_quiet", mem_req, 0);

    // Flush during a store: store still completes.
    ex_req = 1'b1; ex_we = 1'b1; ex_addr = 32'h2400; ex_wdata = 32'h12345678; ex_be = 4'hC;
    expect_issue(1'b1, 32'h2400, 32'h12345678, 4'hC);
    step();
    chk_issue("flush_store");
    flush = 1'b1;
    step();
    chk("flush_store_state", dut.state_q, StBusyEx);
    chk("flush_store_req", mem_req, 1);
    do_ack(32'h0, 1'b0, 1'b1, 1'b1, "flush_store");
    ex_req = 1'b0; ex_we = 1'b0;
    step();

    // Reset mid-transaction, then a stray ack.
    ex_req = 1'b1; ex_we = 1'b0; ex_addr = 32'h2800; ex_wdata = '0; ex_be = 4'hF;
    expect_issue(1'b0, 32'h2800, 32'h0, 4'hF);
    step();
    chk_issue("rst_mid");
    rst_n = 1'b0;
    #1;
    chk("rst_mid_req", mem_req, 0);
    chk("rst_mid_addr", mem_addr, 0);
    chk("rst_mid_state", dut.state_q, StIdle);
    chk("rst_mid_busy", mau_busy, 0);
    ex_req = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    mem_ack = 1'b1; mem_rdata = 32'h77777777;
    #1;
    chk("stray_if_ack", if_ack, 0);
    chk("stray_ex_ack", ex_ack, 0);
    step();
    chk("stray_no_req", mem_req, 0);
    mem_ack = 1'b0;
    step();
    chk("stray_idle", dut.state_q, StIdle);
    chk("sb_empty", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
